// File: rtl/sha256_pkg.sv
//------------------------------------------------------------------------------
// Module   : sha256_pkg
// Brief    : Shared constants and padder FSM state encoding for SHA-256 blocks.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      PAD   = 2'd1,
      LEN   = 2'd2,
      EMIT  = 2'd3
   } state_t;

   localparam int         BLK_BYTES     = 64;
   localparam int         LEN_FIELD_POS = 56;
   localparam logic [7:0] PAD_BYTE      = 8'h80;

endpackage

`default_nettype wire

// File: rtl/sha256_padder.sv
//------------------------------------------------------------------------------
// Module   : sha256_padder
// Brief    : Packs a byte stream into 512-bit SHA-256 blocks with 0x80 / length padding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_padder #(
   parameter int LEN_W = 64
) (
   input  logic         usr_clk,
   input  logic         usr_reset,
   input  logic [7:0]   i_byte,
   input  logic         i_valid,
   input  logic         i_last,
   output logic         o_ready,
   output logic [511:0] o_block,
   output logic         o_blk_valid,
   input  logic         i_blk_ready,
   output logic         o_first_blk,
   output logic         o_last_blk
);

   import sha256_pkg::*;

   localparam logic [5:0] PTR_MAX     = 6'(BLK_BYTES - 1);
   localparam logic [5:0] PAD_PTR_MAX = 6'(LEN_FIELD_POS - 1);

   state_t             r_state;
   logic [5:0]         r_ptr;
   logic [LEN_W-1:0]   r_cnt;
   logic [511:0]       r_buf;
   logic               r_pad_pend;
   logic               r_len_pend;
   logic               r_first;
   logic               r_last;
   logic               r_ready;
   logic               r_blk_valid;

   logic [8:0]         w_wr_lsb;
   logic [63:0]        w_len_field;

   // Byte k lives at bits [511-8k -: 8]; its LSB is 8*(63-k) = {~k, 3'b000}.
   assign w_wr_lsb = {~r_ptr, 3'b000};

   always_comb begin
      w_len_field              = '0;
      w_len_field[LEN_W-1:0]   = r_cnt;
   end

   always_ff @(posedge usr_clk or posedge usr_reset) begin
      if (usr_reset) begin
         r_state     <= ACCUM;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_buf       <= '0;
         r_pad_pend  <= 1'b0;
         r_len_pend  <= 1'b0;
         r_first     <= 1'b1;
         r_last      <= 1'b0;
         r_ready     <= 1'b1;
         r_blk_valid <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (i_valid) begin
                  r_buf[w_wr_lsb +: 8] <= i_byte;
                  r_ptr                <= r_ptr + 6'd1;
                  r_cnt                <= r_cnt + LEN_W'(8);
                  if (r_ptr == PTR_MAX) begin
                     r_state     <= EMIT;
                     r_ready     <= 1'b0;
                     r_blk_valid <= 1'b1;
                     r_pad_pend  <= i_last;
                  end else if (i_last) begin
                     r_state <= PAD;
                     r_ready <= 1'b0;
                  end
               end
            end
            PAD: begin
               r_buf[w_wr_lsb +: 8] <= PAD_BYTE;
               if (r_ptr <= PAD_PTR_MAX) begin
                  r_state <= LEN;
               end else begin
                  // No room for the length field: it goes into a follow-up block.
                  r_state     <= EMIT;
                  r_blk_valid <= 1'b1;
                  r_len_pend  <= 1'b1;
               end
            end
            LEN: begin
               r_buf[63:0] <= w_len_field;
               r_last      <= 1'b1;
               r_state     <= EMIT;
               r_blk_valid <= 1'b1;
            end
            EMIT: begin
               if (i_blk_ready) begin
                  r_buf       <= '0;
                  r_ptr       <= '0;
                  r_blk_valid <= 1'b0;
                  r_first     <= r_last;
                  r_last      <= 1'b0;
                  if (r_pad_pend) begin
                     r_state    <= PAD;
                     r_pad_pend <= 1'b0;
                  end else if (r_len_pend) begin
                     r_state    <= LEN;
                     r_len_pend <= 1'b0;
                  end else begin
                     r_state <= ACCUM;
                     r_ready <= 1'b1;
                     if (r_last) begin
                        r_cnt <= '0;
                     end
                  end
               end
            end
            default: begin
               r_state <= ACCUM;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready     = r_ready;
   assign o_block     = r_buf;
   assign o_blk_valid = r_blk_valid;
   assign o_first_blk = r_first;
   assign o_last_blk  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_sha256_padder.sv
//------------------------------------------------------------------------------
// Module   : tb_sha256_padder
// Brief    : Randomized self-checking bench for sha256_padder against a padding model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sha256_padder;

   logic         usr_clk = 1'b0;
   logic         usr_reset = 1'b0;
   logic [7:0]   i_byte = 8'h00;
   logic         i_valid = 1'b0;
   logic         i_last = 1'b0;
   logic         o_ready;
   logic [511:0] o_block;
   logic         o_blk_valid;
   logic         i_blk_ready = 1'b1;
   logic         o_first_blk;
   logic         o_last_blk;

   sha256_padder #(.LEN_W(64)) dut (
      .usr_clk     (usr_clk),
      .usr_reset   (usr_reset),
      .i_byte      (i_byte),
      .i_valid     (i_valid),
      .i_last      (i_last),
      .o_ready     (o_ready),
      .o_block     (o_block),
      .o_blk_valid (o_blk_valid),
      .i_blk_ready (i_blk_ready),
      .o_first_blk (o_first_blk),
      .o_last_blk  (o_last_blk)
   );

   always #5 usr_clk = ~usr_clk;

   typedef struct {
      logic [511:0] data;
      bit           first;
      bit           last;
      bit           kind;   // 0: triggered by a byte accept, 1: by previous handshake
      int           trig;
      int           gap;
   } exp_t;

   exp_t         q[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           acc_cnt = 0;
   int           sent_total = 0;
   int           t_exp = -1;
   int           rdy_mode = 0;
   bit           prev_v = 0;
   bit           prev_hs = 0;
   logic [511:0] prev_blk = '0;
   logic         prev_first = 0;
   logic         prev_last = 0;
   logic [511:0] capt_blk = '0;
   logic         capt_first = 0;
   logic         capt_last = 0;

   localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Standard SHA-256 padding of a whole message, then split into 64-byte blocks.
   function automatic void model(input logic [7:0] msg[$], input int base, output exp_t blks[$]);
      logic [7:0]  p[$];
      int          L;
      int          n;
      logic [63:0] bits;
      L    = msg.size();
      bits = 64'(L) * 64'd8;
      p    = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int k = 0; k < 8; k++) p.push_back(bits[63-8*k -: 8]);
      n = p.size() / 64;
      blks.delete();
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.data = '0;
         for (int k = 0; k < 64; k++) e.data[511-8*k -: 8] = p[64*i+k];
         e.first = (i == 0);
         e.last  = (i == n - 1);
         if (64*i + 64 <= L) begin
            e.kind = 0; e.trig = base + 64*i + 64; e.gap = 1;
         end else if (64*i <= L - 1) begin
            e.kind = 0; e.trig = base + L; e.gap = (L % 64 <= 55) ? 3 : 2;
         end else begin
            e.kind = 1; e.trig = 0; e.gap = (L % 64 == 0) ? 3 : 2;
         end
         blks.push_back(e);
      end
   endfunction

   always @(posedge usr_clk) cyc++;

   always @(posedge usr_clk) begin
      #1;
      case (rdy_mode)
         0:       i_blk_ready = 1'b1;
         1:       i_blk_ready = ($urandom_range(0, 2) != 0);
         default: i_blk_ready = 1'b0;
      endcase
   end

   // Compare process: every cycle a block is presented, check it against the model queue.
   always @(negedge usr_clk) begin
      if (usr_reset) begin
         acc_cnt = 0; prev_v = 0; prev_hs = 0; t_exp = -1;
      end else begin
         if (i_valid && o_ready) begin
            acc_cnt++;
            if (q.size() > 0 && q[0].kind == 0 && q[0].trig == acc_cnt) t_exp = cyc + q[0].gap;
         end
         if (o_blk_valid) begin
            chk("ready_low_in_emit", 512'(o_ready), 512'd0);
            if (!prev_v) begin
               if (q.size() == 0) chk("unexpected_block", 512'd1, 512'd0);
               else chk("blk_latency", 512'(cyc), 512'(t_exp));
            end else if (!prev_hs) begin
               chk("blk_stable", o_block, prev_blk);
               chk("first_stable", 512'(o_first_blk), 512'(prev_first));
               chk("last_stable", 512'(o_last_blk), 512'(prev_last));
            end
            if (q.size() > 0) begin
               chk("blk_data", o_block, q[0].data);
               chk("blk_first", 512'(o_first_blk), 512'(q[0].first));
               chk("blk_last", 512'(o_last_blk), 512'(q[0].last));
            end
            if (i_blk_ready) begin
               capt_blk = o_block; capt_first = o_first_blk; capt_last = o_last_blk;
               if (q.size() > 0) void'(q.pop_front());
               t_exp = -1;
               if (q.size() > 0 && q[0].kind == 1) t_exp = cyc + q[0].gap;
               prev_hs = 1;
            end else begin
               prev_hs = 0;
            end
         end else begin
            prev_hs = 0;
         end
         prev_v = o_blk_valid; prev_blk = o_block;
         prev_first = o_first_blk; prev_last = o_last_blk;
      end
   end

   task automatic do_reset();
      q.delete();
      sent_total = 0;
      usr_reset = 1'b1;
      #1;
      chk("rst_ready", 512'(o_ready), 512'd1);
      chk("rst_blk_valid", 512'(o_blk_valid), 512'd0);
      chk("rst_block", o_block, 512'd0);
      chk("rst_first", 512'(o_first_blk), 512'd1);
      chk("rst_last", 512'(o_last_blk), 512'd0);
      repeat (2) @(posedge usr_clk);
      #1;
      usr_reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      bit ok;
      int guard;
      guard = 0;
      ok = 0;
      while ($urandom_range(0, 3) == 0) begin
         i_valid = 1'b0; i_last = 1'($urandom_range(0, 1)); i_byte = 8'($urandom);
         @(posedge usr_clk); #1;
      end
      i_valid = 1'b1; i_byte = b; i_last = last;
      do begin
         @(negedge usr_clk); ok = o_ready;
         @(posedge usr_clk); #1;
         guard++;
      end while (!ok && guard < 400);
      if (!ok) chk("byte_accept_timeout", 512'd0, 512'd1);
      i_valid = 1'b0; i_last = 1'b0;
   endtask

   task automatic send_msg(input logic [7:0] msg[$], input bit last_flag, input bit push);
      exp_t blks[$];
      if (push) begin
         model(msg, sent_total, blks);
         foreach (blks[i]) q.push_back(blks[i]);
      end
      foreach (msg[i]) send_byte(msg[i], last_flag && (i == msg.size() - 1));
      sent_total += msg.size();
   endtask

   task automatic rand_msg(input int len, output logic [7:0] msg[$]);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 3000) begin
         @(posedge usr_clk); guard++;
      end
      if (q.size() > 0) chk("drain_timeout", 512'(q.size()), 512'd0);
      q.delete();
      repeat (2) @(posedge usr_clk);
      #1;
   endtask

   task automatic wait_valid();
      int guard;
      guard = 0;
      while (!o_blk_valid && guard < 50) begin
         @(negedge usr_clk); guard++;
      end
      if (!o_blk_valid) chk("wait_valid_timeout", 512'd0, 512'd1);
   endtask

   initial begin
      logic [7:0] msg[$];
      exp_t       blks[$];
      int         acc0;

      // Pin the model with hand-derived blocks.
      msg = '{8'h61, 8'h62, 8'h63};
      model(msg, 0, blks);
      chk("model_abc_count", 512'(blks.size()), 512'd1);
      chk("model_abc", blks[0].data, ABC_BLK);
      rand_msg(55, msg); model(msg, 0, blks);
      chk("model55_count", 512'(blks.size()), 512'd1);
      chk("model55_pad", 512'(blks[0].data[511-8*55 -: 8]), 512'h80);
      chk("model55_len", 512'(blks[0].data[63:0]), 512'h1B8);
      rand_msg(56, msg); model(msg, 0, blks);
      chk("model56_pad", 512'(blks[0].data[511-8*56 -: 8]), 512'h80);
      chk("model56_len", blks[1].data, 512'h1C0);
      rand_msg(64, msg); model(msg, 0, blks);
      chk("model64_blk2", blks[1].data, {8'h80, 440'h0, 64'h200});

      @(posedge usr_clk); #1;
      do_reset();

      rdy_mode = 0;
      msg = '{8'h61, 8'h62, 8'h63};
      send_msg(msg, 1, 1); drain();
      chk("abc_block", capt_blk, ABC_BLK);
      chk("abc_first", 512'(capt_first), 512'd1);
      chk("abc_last", 512'(capt_last), 512'd1);

      rand_msg(55, msg); send_msg(msg, 1, 1); drain();
      rand_msg(56, msg); send_msg(msg, 1, 1); drain();
      rand_msg(64, msg); send_msg(msg, 1, 1); drain();

      // Backpressure: a stalled block must hold and refuse input bytes.
      rdy_mode = 2;
      rand_msg(64, msg); send_msg(msg, 1, 1);
      wait_valid();
      @(posedge usr_clk); #1;
      acc0 = acc_cnt;
      i_valid = 1'b1; i_byte = 8'h5A; i_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge usr_clk);
         chk("hold_ready", 512'(o_ready), 512'd0);
         chk("hold_no_consume", 512'(acc_cnt), 512'(acc0));
      end
      @(posedge usr_clk); #1;
      i_valid = 1'b0;
      rdy_mode = 0;
      drain();

      rdy_mode = 1;
      for (int m = 0; m < 12; m++) begin
         rand_msg($urandom_range(1, 150), msg);
         send_msg(msg, 1, 1);
      end
      drain();

      // Reset in the middle of a message.
      rdy_mode = 0;
      rand_msg(30, msg); send_msg(msg, 0, 0);
      do_reset();
      msg = '{8'h61, 8'h62, 8'h63};
      send_msg(msg, 1, 1); drain();
      chk("rst_mid_abc", capt_blk, ABC_BLK);
      chk("rst_mid_first", 512'(capt_first), 512'd1);

      // Reset while a block is stalled in EMIT.
      rdy_mode = 2;
      rand_msg(64, msg); send_msg(msg, 1, 1);
      wait_valid();
      @(posedge usr_clk); #1;
      rdy_mode = 0;
      do_reset();
      msg = '{8'h61, 8'h62, 8'h63};
      send_msg(msg, 1, 1); drain();
      chk("rst_emit_abc", capt_blk, ABC_BLK);
      chk("rst_emit_first", 512'(capt_first), 512'd1);
      chk("rst_emit_last", 512'(capt_last), 512'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 The module SHALL have parameter LEN_W, default 64, meaning the width of the message bit-length counter and of the appended length field.
REQ-002 The module SHALL have port usr_clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-003 The module SHALL have port usr_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have ports i_byte (input, 8 bits), i_valid (input, 1 bit) and i_last (input, 1 bit): the message byte stream, with i_last marking the final byte.
REQ-005 The module SHALL have port o_ready, output, 1 bit: a byte is accepted on any edge where i_valid and o_ready are both 1.
REQ-006 The module SHALL have port o_block, output, 512 bits: the padded block, byte k of the block at bits [511-8k : 504-8k] (big-endian).
REQ-007 The module SHALL have ports o_blk_valid (output, 1 bit) and i_blk_ready (input, 1 bit): the block handshake toward the sha_256 core.
REQ-008 The module SHALL have ports o_first_blk and o_last_blk, each output, 1 bit: they flag the first and the final block of a message and are valid while o_blk_valid=1.

Function
REQ-009 The FSM SHALL have exactly four states: ACCUM, PAD, LEN and EMIT.
REQ-010 In ACCUM, o_ready SHALL be 1; each accepted byte is written at byte pointer ptr (0..63), ptr increments, and the bit counter increments by 8.
REQ-011 An accepted byte at ptr=63 SHALL move the FSM to EMIT; if that byte has i_last=1, a pad-pending flag SHALL be set.
REQ-012 An accepted byte with i_last=1 at ptr<63 SHALL move the FSM to PAD.
REQ-013 PAD SHALL take one cycle: write 0x80 at ptr; go to LEN if ptr<=55, otherwise go to EMIT with a len-pending flag set.
REQ-014 LEN SHALL take one cycle: write the bit counter, MSB first, into bytes 56..63, mark the block as last, then go to EMIT.
REQ-015 In EMIT, o_blk_valid SHALL be 1 and o_block SHALL be held stable until i_blk_ready=1 is sampled.
REQ-016 On the EMIT handshake, the buffer SHALL be cleared to zero (zero fill is implicit) and ptr SHALL reset to 0.
REQ-017 The next state after the EMIT handshake SHALL be PAD if pad-pending, else LEN if len-pending, else ACCUM if the block was last (the bit counter also clears), else ACCUM to continue the message.
REQ-018 o_ready SHALL be 0 in PAD, LEN and EMIT; no input byte is dropped or reordered.
REQ-019 o_first_blk SHALL be 1 for the first block emitted after reset or after a last block.
REQ-020 o_last_blk SHALL be 1 only for the block containing the length field.
REQ-021 Latency: the last byte accepted at ptr<=54 in cycle t SHALL give PAD at t+1, LEN at t+2 and o_blk_valid at t+3.
REQ-022 After an EMIT handshake at cycle h with len-pending set, o_blk_valid SHALL be asserted again at h+2.
REQ-023 The bit counter SHALL wrap modulo 2^LEN_W without error indication.
REQ-024 Zero-length messages are not supported; i_last always accompanies a data byte.
REQ-025 i_last with i_valid=0 SHALL be ignored.

Reset
REQ-026 Asserting usr_reset at any time SHALL immediately set FSM=ACCUM, ptr=0, bit counter=0, buffer=0, pad-pending=0, len-pending=0 and first-flag=1.
REQ-027 During reset, outputs SHALL be o_ready=1, o_blk_valid=0, o_block=0, o_first_blk=1 and o_last_blk=0.
REQ-028 A reset in mid-message or mid-EMIT SHALL discard the partial message, and no block SHALL be emitted for it.

Structure
REQ-029 A shared package sha256_pkg SHALL hold: the FSM state enum, BLK_BYTES=64, LEN_FIELD_POS=56 and PAD_BYTE=8'h80.
REQ-030 The padder SHALL be a single module; no sub-module is required.
REQ-031 o_block/o_blk_valid SHALL connect directly to the sha_256 core's i_msg/i_start.

Verification
REQ-032 Send "abc" (61 62 63, last on 63) with i_blk_ready=1 -> one block 6162638000...0018 with first=1 and last=1, o_blk_valid exactly 3 cycles after the last byte.
REQ-033 Send a 55-byte message -> one block with byte 55=0x80 and length 0x1B8.
REQ-034 Send a 56-byte message -> two blocks: block 1 has 0x80 at byte 56 and is not last; block 2 is all zero except the length 0x1C0, with last=1, asserted 2 cycles after the block-1 handshake.
REQ-035 Send a 64-byte message -> two blocks: block 1 is the data; block 2 is 0x80 at byte 0 plus length 0x200 with last=1.
REQ-036 Hold i_blk_ready=0 for 10 cycles in EMIT -> o_block stable, o_ready=0, and no input bytes are consumed.
REQ-037 Assert usr_reset after 30 bytes of a message, then send "abc" -> output is identical to REQ-032 with first=1.
